exe_operand_reg: RTL and testbench

EXE_OPERAND_REG -- requirements
Module: exe_operand_reg
Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 d_ra, d_rb  in  32 each  register-file read data for rs and rt from the ID stage.
REQ-004 d_imm  in  32  already-extended immediate from ID.
REQ-005 d_sa  in  5  shift amount field from ID.
REQ-006 d_rs, d_rt  in  5 each  source register numbers from ID.
REQ-007 d_aluc  in  4  ALU opcode from ID, encoded as the ALU expects: x000 ADD, x100 SUB, x001 AND, x101 OR, x010 XOR, x110 LUI, 0011 SLL, 0111 SRL, 1111 SRA.
REQ-008 d_aluimm, d_shift  in  1 each  select immediate as B operand; select shift amount as A operand.
REQ-009 d_wreg, d_m2reg, d_rn  in  1/1/5  register-write enable, load flag, destination number from ID.
REQ-010 ex_result  in  32  combinational ALU result of the instruction currently held in this stage.
REQ-011 m_wreg, m_rn, m_data  in  1/5/32  MEM-stage write enable, destination and write-back value.
REQ-012 stall  in  1  downstream hold request.
REQ-013 flush  in  1  branch/jump squash of the ID instruction.
REQ-014 alua, alub  out  32 each  registered ALU operands.
REQ-015 aluc  out  4  registered ALU opcode.
REQ-016 e_wreg, e_m2reg, e_rn  out  1/1/5  registered control passed to EX/MEM.
REQ-017 stall_req  out  1  combinational load-use stall request to PC/IF/ID.
Function
REQ-018 Forwarded A value: EX hit if e_wreg & ~e_m2reg & e_rn!=0 & e_rn==d_rs (use ex_result); else MEM hit if m_wreg & m_rn!=0 & m_rn==d_rs (use m_data); else d_ra. EX has priority over MEM.
REQ-019 Forwarded B value: same rule with d_rt and d_rb.
REQ-020 Register 0 is never forwarded; source 0 always uses the register-file value.
REQ-021 Next alua = d_shift ? {27'b0, d_sa} : forwarded A. Next alub = d_aluimm ? d_imm : forwarded B.
REQ-022 stall_req = e_m2reg & e_wreg & e_rn!=0 & (e_rn==d_rs | e_rn==d_rt). The check is conservative and ignores whether the source is actually used.
REQ-023 Bubble state: alua=0, alub=0, aluc=0, e_wreg=0, e_m2reg=0, e_rn=0.
REQ-024 Per-edge update priority: reset, then bubble if flush=1 or stall_req=1, then hold all registers if stall=1, else load the next values.
REQ-025 Flush or load-use together with stall=1: the bubble wins; the held instruction is the one being replaced and upstream re-issues it.
REQ-026 Latency is one cycle from ID inputs to outputs. There is no handshake beyond stall, flush and stall_req.
REQ-027 A load-use stall inserts exactly one bubble. On the next cycle e_m2reg=0, stall_req drops, and the dependent instruction gets the loaded value via the MEM forward.
REQ-028 While stall=1, forwarding inputs are not sampled into held registers, and the outputs stay stable.
Reset
REQ-029 When reset=1 at an edge, all outputs take the bubble state, and stall_req evaluates to 0 on the following cycle.
REQ-030 Reset asserted mid-stall or mid-flush overrides both; there is no reset-to-stall carry-over.
Structure
REQ-031 ALUC encodings and the 5-bit register-number width belong in the shared CPU package, also used by decode and ALU; the bubble value is a package constant.
REQ-032 One sub-module, fwd_mux (one instance per operand), implements REQ-018/019; the registers and hazard logic stay in the top.
Verification
REQ-033 EX forward: prior instr e_rn=5 ALU with ex_result=0x1234; d_rs=5, d_ra=0 -> next alua=0x00001234.
REQ-034 Priority: EX e_rn=3 result 0xAAAA and MEM m_rn=3 data 0xBBBB both hit d_rt=3 -> alub=0x0000AAAA; with d_rt=0 -> alub=d_rb.
REQ-035 Load-use: e_m2reg=1, e_wreg=1, e_rn=8, d_rs=8 -> stall_req=1, next cycle bubble; then stall_req=0 and m_data=0x55 is forwarded -> alua=0x55.
REQ-036 Shift/imm select: d_shift=1, d_sa=31, d_aluimm=1, d_imm=0xFFFF8000, d_aluc=1111 -> alua=31, alub=0xFFFF8000, aluc=1111.
REQ-037 Control: stall=1 for 3 cycles -> outputs unchanged; flush=1 with stall=1 -> bubble; reset=1 mid-stall -> all outputs 0.

---
 rtl/exe_operand_reg_pkg.sv | 51 +++++
 rtl/exe_operand_reg_fwd.sv | 44 ++++
 rtl/exe_operand_reg.sv | 115 +++++++++++
 tb/tb_exe_operand_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/exe_operand_reg_pkg.sv
// Shared CPU definitions: datapath and register-number widths, ALU opcode
// encodings, the ID/EX stage payload and its bubble value.
package exe_operand_reg_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ALUC_W = 4;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_num_t;
    typedef logic [ALUC_W-1:0] aluc_t;

    // ALU opcodes; bit 3 is don't-care for the non-shift group, shown as 0.
    localparam aluc_t ALUC_ADD = 4'b0000;
    localparam aluc_t ALUC_SUB = 4'b0100;
    localparam aluc_t ALUC_AND = 4'b0001;
    localparam aluc_t ALUC_OR  = 4'b0101;
    localparam aluc_t ALUC_XOR = 4'b0010;
    localparam aluc_t ALUC_LUI = 4'b0110;
    localparam aluc_t ALUC_SLL = 4'b0011;
    localparam aluc_t ALUC_SRL = 4'b0111;
    localparam aluc_t ALUC_SRA = 4'b1111;

    localparam reg_num_t REG_ZERO = '0;

    // Everything the EX stage holds for one instruction.
    typedef struct packed {
        word_t    alua;
        word_t    alub;
        aluc_t    aluc;
        logic     wreg;
        logic     m2reg;
        reg_num_t rn;
    } ex_ctl_t;

    // A bubble writes nothing and is not a load, so it never forwards or stalls.
    localparam ex_ctl_t EX_BUBBLE = '{
        alua:  '0,
        alub:  '0,
        aluc:  ALUC_ADD,
        wreg:  1'b0,
        m2reg: 1'b0,
        rn:    REG_ZERO
    };

    // True when a producer writing register rn supplies source src; r0 never matches.
    function automatic logic src_hit(input logic wreg, input reg_num_t rn, input reg_num_t src);
        return wreg && (rn != REG_ZERO) && (rn == src);
    endfunction

endpackage

// File: rtl/exe_operand_reg_fwd.sv
// fwd_mux: selects one source operand from the EX result, the MEM write-back
// value or the register file. EX is newer than MEM so it takes priority; a
// load in EX has no result yet and is excluded (the hazard logic stalls it).
// Ports:
//   e_wreg, e_m2reg, e_rn   - instruction currently in EX
//   ex_result               - combinational ALU result of that instruction
//   m_wreg, m_rn, m_data    - instruction currently in MEM and its value
//   src, rf_data            - source register number and register-file data
//   fwd_data_c              - forwarded operand (combinational)
module fwd_mux
    import exe_operand_reg_pkg::*;
(
    input  logic     e_wreg,
    input  logic     e_m2reg,
    input  reg_num_t e_rn,
    input  word_t    ex_result,
    input  logic     m_wreg,
    input  reg_num_t m_rn,
    input  word_t    m_data,
    input  reg_num_t src,
    input  word_t    rf_data,
    output word_t    fwd_data_c
);

    logic ex_hit_c;
    logic mem_hit_c;

    // Hit detection for each producer stage.
    always_comb begin
        ex_hit_c  = src_hit(e_wreg & ~e_m2reg, e_rn, src);
        mem_hit_c = src_hit(m_wreg, m_rn, src);
    end

    // Priority select: EX, then MEM, then register file.
    always_comb begin
        fwd_data_c = rf_data;
        if (ex_hit_c) begin
            fwd_data_c = ex_result;
        end else if (mem_hit_c) begin
            fwd_data_c = m_data;
        end
    end

endmodule

// File: rtl/exe_operand_reg.sv
// exe_operand_reg: ID/EX pipeline register. Captures forwarded and selected
// ALU operands plus control for the EX stage, inserts bubbles on flush or
// load-use hazard, and holds on a downstream stall.
// Ports:
//   clock, reset             - clock, synchronous active-high reset
//   d_*                      - decoded instruction from ID
//   ex_result                - ALU result of the instruction held here
//   m_wreg, m_rn, m_data     - MEM-stage write-back for forwarding
//   stall, flush             - downstream hold, squash of the ID instruction
//   alua, alub, aluc         - registered ALU operands and opcode
//   e_wreg, e_m2reg, e_rn    - registered control to EX/MEM
//   stall_req                - combinational load-use stall to PC/IF/ID
module exe_operand_reg
    import exe_operand_reg_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  word_t    d_ra,
    input  word_t    d_rb,
    input  word_t    d_imm,
    input  reg_num_t d_sa,
    input  reg_num_t d_rs,
    input  reg_num_t d_rt,
    input  aluc_t    d_aluc,
    input  logic     d_aluimm,
    input  logic     d_shift,
    input  logic     d_wreg,
    input  logic     d_m2reg,
    input  reg_num_t d_rn,
    input  word_t    ex_result,
    input  logic     m_wreg,
    input  reg_num_t m_rn,
    input  word_t    m_data,
    input  logic     stall,
    input  logic     flush,
    output word_t    alua,
    output word_t    alub,
    output aluc_t    aluc,
    output logic     e_wreg,
    output logic     e_m2reg,
    output reg_num_t e_rn,
    output logic     stall_req
);

    ex_ctl_t stage_q;
    ex_ctl_t stage_d;
    word_t   fwd_a_c;
    word_t   fwd_b_c;

    fwd_mux u_fwd_a (
        .e_wreg     (stage_q.wreg),
        .e_m2reg    (stage_q.m2reg),
        .e_rn       (stage_q.rn),
        .ex_result  (ex_result),
        .m_wreg     (m_wreg),
        .m_rn       (m_rn),
        .m_data     (m_data),
        .src        (d_rs),
        .rf_data    (d_ra),
        .fwd_data_c (fwd_a_c)
    );

    fwd_mux u_fwd_b (
        .e_wreg     (stage_q.wreg),
        .e_m2reg    (stage_q.m2reg),
        .e_rn       (stage_q.rn),
        .ex_result  (ex_result),
        .m_wreg     (m_wreg),
        .m_rn       (m_rn),
        .m_data     (m_data),
        .src        (d_rt),
        .rf_data    (d_rb),
        .fwd_data_c (fwd_b_c)
    );

    // Load in EX feeding either source of the ID instruction; deliberately
    // ignores whether that source is actually used.
    always_comb begin
        stall_req = stage_q.wreg && stage_q.m2reg && (stage_q.rn != REG_ZERO) &&
                    ((stage_q.rn == d_rs) || (stage_q.rn == d_rt));
    end

    // Next state: bubble beats hold, since the held instruction is being
    // replaced and will be re-issued from upstream.
    always_comb begin
        stage_d = stage_q;
        if (flush || stall_req) begin
            stage_d = EX_BUBBLE;
        end else if (!stall) begin
            stage_d.alua  = d_shift  ? word_t'(d_sa) : fwd_a_c;
            stage_d.alub  = d_aluimm ? d_imm         : fwd_b_c;
            stage_d.aluc  = d_aluc;
            stage_d.wreg  = d_wreg;
            stage_d.m2reg = d_m2reg;
            stage_d.rn    = d_rn;
        end
    end

    // Stage register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q <= EX_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign alua    = stage_q.alua;
    assign alub    = stage_q.alub;
    assign aluc    = stage_q.aluc;
    assign e_wreg  = stage_q.wreg;
    assign e_m2reg = stage_q.m2reg;
    assign e_rn    = stage_q.rn;

endmodule

// File: tb/tb_exe_operand_reg.sv
// Directed bench for exe_operand_reg: forwarding, priority, load-use bubble,
// shift/immediate select, stall hold, flush and reset behaviour.
module tb_exe_operand_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] d_ra, d_rb, d_imm, ex_result, m_data;
    logic [4:0]  d_sa, d_rs, d_rt, d_rn, m_rn;
    logic [3:0]  d_aluc;
    logic        d_aluimm, d_shift, d_wreg, d_m2reg, m_wreg, stall, flush;
    logic [31:0] alua, alub;
    logic [3:0]  aluc;
    logic        e_wreg, e_m2reg, stall_req;
    logic [4:0]  e_rn;

    int total = 0;
    int bad   = 0;

    exe_operand_reg dut (
        .clock     (clock),
        .reset     (reset),
        .d_ra      (d_ra),
        .d_rb      (d_rb),
        .d_imm     (d_imm),
        .d_sa      (d_sa),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_aluc    (d_aluc),
        .d_aluimm  (d_aluimm),
        .d_shift   (d_shift),
        .d_wreg    (d_wreg),
        .d_m2reg   (d_m2reg),
        .d_rn      (d_rn),
        .ex_result (ex_result),
        .m_wreg    (m_wreg),
        .m_rn      (m_rn),
        .m_data    (m_data),
        .stall     (stall),
        .flush     (flush),
        .alua      (alua),
        .alub      (alub),
        .aluc      (aluc),
        .e_wreg    (e_wreg),
        .e_m2reg   (e_m2reg),
        .e_rn      (e_rn),
        .stall_req (stall_req)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every registered output against one expected EX state.
    task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [3:0] ec, input logic ew, input logic em, input logic [4:0] er);
        chk({tag, ".alua"},    alua,           ea);
        chk({tag, ".alub"},    alub,           eb);
        chk({tag, ".aluc"},    32'(aluc),      32'(ec));
        chk({tag, ".e_wreg"},  32'(e_wreg),    32'(ew));
        chk({tag, ".e_m2reg"}, 32'(e_m2reg),   32'(em));
        chk({tag, ".e_rn"},    32'(e_rn),      32'(er));
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [31:0] ra, input logic [4:0] rt,
                             input logic [31:0] rb, input logic [3:0] op, input logic wr,
                             input logic ld, input logic [4:0] rn);
        d_rs = rs; d_ra = ra; d_rt = rt; d_rb = rb; d_aluc = op;
        d_wreg = wr; d_m2reg = ld; d_rn = rn;
        d_shift = 1'b0; d_aluimm = 1'b0; d_sa = 5'd0; d_imm = 32'h0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        m_wreg = 1'b0; m_rn = 5'd0; m_data = 32'h0; ex_result = 32'h0;
        set_instr(5'd1, 32'h1111, 5'd2, 32'h2222, 4'b0101, 1'b1, 1'b1, 5'd9);

        // Reset gives the bubble state.
        tick();
        chk_all("reset", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0);
        chk("reset.stall_req", 32'(stall_req), 32'h0);

        // Plain load, no forwarding.
        reset = 1'b0;
        set_instr(5'd1, 32'h11, 5'd2, 32'h22, 4'b0000, 1'b1, 1'b0, 5'd5);
        tick();
        chk_all("plain", 32'h11, 32'h22, 4'h0, 1'b1, 1'b0, 5'd5);

        // EX forward onto A.
        ex_result = 32'h1234;
        set_instr(5'd5, 32'h0, 5'd0, 32'h77, 4'b0100, 1'b1, 1'b0, 5'd3);
        #1 chk("exfwd.stall_req", 32'(stall_req), 32'h0);
        tick();
        chk_all("exfwd", 32'h1234, 32'h77, 4'h4, 1'b1, 1'b0, 5'd3);

        // EX beats MEM on B.
        ex_result = 32'hAAAA;
        m_wreg = 1'b1; m_rn = 5'd3; m_data = 32'hBBBB;
        set_instr(5'd0, 32'h5, 5'd3, 32'h99, 4'b0001, 1'b1, 1'b0, 5'd3);
        tick();
        chk_all("prio", 32'h5, 32'hAAAA, 4'h1, 1'b1, 1'b0, 5'd3);

        // Register 0 source never forwards.
        set_instr(5'd0, 32'h1, 5'd0, 32'hCAFE, 4'b0010, 1'b0, 1'b0, 5'd7);
        tick();
        chk_all("r0", 32'h1, 32'hCAFE, 4'h2, 1'b0, 1'b0, 5'd7);

        // MEM-only forward (EX does not write); next instr is a load to r8.
        ex_result = 32'hEEE;
        m_wreg = 1'b1; m_rn = 5'd7; m_data = 32'h777;
        set_instr(5'd7, 32'h10, 5'd9, 32'h20, 4'b0110, 1'b1, 1'b1, 5'd8);
        tick();
        chk_all("memfwd", 32'h777, 32'h20, 4'h6, 1'b1, 1'b1, 5'd8);

        // Load-use: stall_req, one bubble, then MEM forward of the load data.
        m_wreg = 1'b0;
        set_instr(5'd8, 32'h3, 5'd0, 32'h4, 4'b0000, 1'b1, 1'b0, 5'd4);
        #1 chk("lu.stall_req_hi", 32'(stall_req), 32'h1);
        tick();
        chk_all("lu.bubble", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0);
        chk("lu.stall_req_lo", 32'(stall_req), 32'h0);
        m_wreg = 1'b1; m_rn = 5'd8; m_data = 32'h55;
        tick();
        chk_all("lu.fwd", 32'h55, 32'h4, 4'h0, 1'b1, 1'b0, 5'd4);

        // Shift amount and immediate selects override forwarding.
        m_wreg = 1'b0;
        set_instr(5'd4, 32'h3, 5'd4, 32'h4, 4'b1111, 1'b1, 1'b0, 5'd6);
        d_shift = 1'b1; d_sa = 5'd31; d_aluimm = 1'b1; d_imm = 32'hFFFF8000;
        tick();
        chk_all("shimm", 32'd31, 32'hFFFF8000, 4'hF, 1'b1, 1'b0, 5'd6);

        // Stall holds for three cycles even with changing forward inputs.
        set_instr(5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 4'b0001, 1'b1, 1'b0, 5'd9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_result = 32'(i) + 32'h100;
            tick();
            chk_all("hold", 32'd31, 32'hFFFF8000, 4'hF, 1'b1, 1'b0, 5'd6);
        end

        // Release loads the waiting instruction.
        stall = 1'b0;
        tick();
        chk_all("release", 32'hDEAD, 32'hBEEF, 4'h1, 1'b1, 1'b0, 5'd9);

        // Flush with stall gives a bubble.
        stall = 1'b1; flush = 1'b1;
        tick();
        chk_all("flushstall", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0);

        // Load into EX, then reset during a stall.
        stall = 1'b0; flush = 1'b0;
        set_instr(5'd1, 32'h42, 5'd2, 32'h43, 4'b0101, 1'b1, 1'b1, 5'd8);
        tick();
        chk_all("preload", 32'h42, 32'h43, 4'h5, 1'b1, 1'b1, 5'd8);
        set_instr(5'd8, 32'h1, 5'd8, 32'h2, 4'b0010, 1'b1, 1'b0, 5'd10);
        #1 chk("pre_rst.stall_req", 32'(stall_req), 32'h1);
        stall = 1'b1; reset = 1'b1;
        tick();
        chk_all("rst_midstall", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0);
        chk("rst.stall_req", 32'(stall_req), 32'h0);

        // No carry-over: next edge after reset loads normally.
        reset = 1'b0; stall = 1'b0;
        tick();
        chk_all("post_rst", 32'h1, 32'h2, 4'h2, 1'b1, 1'b0, 5'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
